// File: rtl/xosera_bus_pkg.sv
// Shared types and constants for the Xosera 8-bit register bus initiator.
// Holds the bus phase enum, strobe/direction encodings and timing limits.
package xosera_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOVER
  } bus_state_t;

  localparam logic cs_ENABLED  = 1'b0;
  localparam logic cs_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;

  localparam int TIMING_MAX = 15;

  // Phase counter reload value: cycles-1, clamped to the 1..15 range.
  function automatic logic [3:0] phase_load(input int cyc);
    int c;
    c = cyc;
    if (c < 1) c = 1;
    if (c > TIMING_MAX) c = TIMING_MAX;
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/xosera_bus_phase_timer.sv
// Loadable 4-bit down-counter timing one bus phase; done when it hits zero.
// Ports: clk, rst_n (async low), load, load_val[3:0], done.
module xosera_bus_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/xosera_bus_initiator.sv
// Host-side initiator: turns 16-bit register requests into two timed byte
// cycles (even/MSB first) on the Xosera 8-bit bus.
// Ports: req_* valid/ready request, rsp_valid_o/rsp_data_o completion,
// bus_* pad-side strobes, address, data and tri-state enable.
// Option: XOSERA_BUS_BYTE_ACCESS_EN adds req_byte_i/req_bytesel_i.
module xosera_bus_initiator
  import xosera_bus_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic [15:0] req_data_i,
`ifdef XOSERA_BUS_BYTE_ACCESS_EN
  input  logic        req_byte_i,
  input  logic        req_bytesel_i,
`endif
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic        bus_bytesel_o,
  output logic [3:0]  bus_reg_num_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam logic [3:0] LD_SETUP   = phase_load(SETUP_CYC);
  localparam logic [3:0] LD_STROBE  = phase_load(STROBE_CYC);
  localparam logic [3:0] LD_HOLD    = phase_load(HOLD_CYC);
  localparam logic [3:0] LD_RECOVER = phase_load(RECOVER_CYC);

  bus_state_t  state;
  logic        byte_idx;
  logic        single;
  logic [15:0] data_q;

  logic        load;
  logic [3:0]  load_val;
  logic        done;
  logic        more;

  logic        req_single;
  logic        req_bsel;
  logic [15:0] wdata;
  logic        first_sel;

`ifdef XOSERA_BUS_BYTE_ACCESS_EN
  assign req_single = req_byte_i;
  assign req_bsel   = req_bytesel_i;
`else
  assign req_single = 1'b0;
  assign req_bsel   = 1'b0;
`endif

  // A byte write repeats its low byte in both halves so either
  // bytesel lane presents req_data_i[7:0].
  assign wdata = req_single ?
                 {req_data_i[7:0], req_data_i[7:0]} :
                 req_data_i;
  assign first_sel = req_single & req_bsel;
  assign more = ~byte_idx & ~single;

  always_comb begin
    load     = 1'b0;
    load_val = 4'd0;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          load     = 1'b1;
          load_val = LD_SETUP;
        end
      end
      SETUP: begin
        if (done) begin
          load     = 1'b1;
          load_val = LD_STROBE;
        end
      end
      STROBE: begin
        if (done) begin
          load     = 1'b1;
          load_val = LD_HOLD;
        end
      end
      HOLD: begin
        if (done) begin
          load     = 1'b1;
          load_val = LD_RECOVER;
        end
      end
      RECOVER: begin
        if (done && more) begin
          load     = 1'b1;
          load_val = LD_SETUP;
        end
      end
      default: ;
    endcase
  end

  xosera_bus_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (reset_n_i),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      byte_idx      <= 1'b0;
      single        <= 1'b0;
      data_q        <= 16'h0000;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 16'h0000;
      bus_cs_n_o    <= cs_DISABLED;
      bus_rd_nwr_o  <= RnW_READ;
      bus_bytesel_o <= 1'b0;
      bus_reg_num_o <= 4'd0;
      bus_data_o    <= 8'h00;
      bus_data_oe_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            state         <= SETUP;
            req_ready_o   <= 1'b0;
            single        <= req_single;
            byte_idx      <= first_sel;
            data_q        <= wdata;
            bus_rd_nwr_o  <= req_rd_nwr_i;
            bus_reg_num_o <= req_reg_num_i;
            bus_bytesel_o <= first_sel;
            bus_data_o    <= first_sel ? wdata[7:0]
                                       : wdata[15:8];
            bus_data_oe_o <= (req_rd_nwr_i == RnW_WRITE);
          end
        end
        SETUP: begin
          if (done) begin
            state      <= STROBE;
            bus_cs_n_o <= cs_ENABLED;
          end
        end
        STROBE: begin
          if (done) begin
            state      <= HOLD;
            bus_cs_n_o <= cs_DISABLED;
            if (bus_rd_nwr_o == RnW_READ) begin
              if (single || byte_idx) begin
                rsp_data_o[7:0] <= bus_data_i;
              end else begin
                rsp_data_o[15:8] <= bus_data_i;
              end
            end
          end
        end
        HOLD: begin
          if (done) begin
            state         <= RECOVER;
            bus_data_oe_o <= 1'b0;
          end
        end
        RECOVER: begin
          if (done) begin
            if (more) begin
              state         <= SETUP;
              byte_idx      <= 1'b1;
              bus_bytesel_o <= 1'b1;
              bus_data_o    <= data_q[7:0];
              bus_data_oe_o <= (bus_rd_nwr_o == RnW_WRITE);
            end else begin
              state       <= IDLE;
              req_ready_o <= 1'b1;
              rsp_valid_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
